pm_loader: RTL

//  Sequences program entry into the BF machine's program memory from board switches.

---
 rtl/pm_loader.sv | 102 ++++++++++
 1 files changed

// File: rtl/pm_loader.sv
// Program-memory loader: one switch byte per enter press, ends on TERMINATOR or full memory.
// Latency: enter rise at edge N -> pm_we high N+1..N+2; no backpressure, held button waits for release.
module pm_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] TERMINATOR = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  enter,
    input  logic [DATA_WIDTH-1:0] DataInputSwitches,
    output logic [ADDR_WIDTH-1:0] pm_addr,
    output logic [DATA_WIDTH-1:0] pm_wdata,
    output logic                  pm_we,
    output logic                  PMInputDone,
    output logic [ADDR_WIDTH:0]   count,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WAIT_PRESS   = 3'd1,
        S_WRITE        = 3'd2,
        S_WAIT_RELEASE = 3'd3,
        S_DONE         = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                cur;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  start_q;
    logic                  enter_q;
    logic                  start_rise;
    logic                  enter_rise;

    assign start_rise = start & ~start_q;
    assign enter_rise = enter & ~enter_q;
    assign state      = cur;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur         <= S_IDLE;
            ptr         <= '0;
            count       <= '0;
            pm_we       <= 1'b0;
            pm_addr     <= '0;
            pm_wdata    <= '0;
            PMInputDone <= 1'b0;
            start_q     <= 1'b0;
            enter_q     <= 1'b0;
        end else begin
            start_q <= start;
            enter_q <= enter;
            pm_we   <= 1'b0;
            case (cur)
                S_IDLE: begin
                    // start wins over a coincident enter rise; enter_q still updates, so a fresh press is needed
                    if (start_rise) begin
                        cur   <= S_WAIT_PRESS;
                        ptr   <= '0;
                        count <= '0;
                    end
                end
                S_WAIT_PRESS: begin
                    if (enter_rise) begin
                        pm_wdata <= DataInputSwitches;
                        pm_addr  <= ptr;
                        pm_we    <= 1'b1;
                        cur      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    count <= count + CNT_ONE;
                    // last address is terminal so ptr never wraps back over written program
                    if (pm_wdata == TERMINATOR || ptr == PTR_MAX) begin
                        cur         <= S_DONE;
                        PMInputDone <= 1'b1;
                    end else begin
                        ptr <= ptr + PTR_ONE;
                        cur <= S_WAIT_RELEASE;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (!enter) begin
                        cur <= S_WAIT_PRESS;
                    end
                end
                S_DONE: begin
                    PMInputDone <= 1'b1;
                end
                default: begin
                    cur <= S_IDLE;
                end
            endcase
        end
    end

endmodule
